// File: rtl/scheduler_pkg.sv
// Shared types and constants for the task scheduler front-end and its slice timer.
package scheduler_pkg;

   localparam int unsigned TID_W    = 6;
   localparam int unsigned PRI_W    = 3;
   localparam int unsigned RL_TID_W = 16;
   localparam int unsigned SLICE_W  = 8;
   localparam int unsigned STAT_W   = 32;

   localparam logic [RL_TID_W-1:0] TID_EMPTY = 16'hFFFF;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      WAIT0  = 3'd2,
      WAIT1  = 3'd3,
      COMMIT = 3'd4
   } sched_state_e;

   // Only the low bits of a ready-list ID name a task; the upper bits are ignored.
   function automatic logic [TID_W-1:0] tid_of(input logic [RL_TID_W-1:0] rl_tid);
      return rl_tid[TID_W-1:0];
   endfunction

endpackage

// File: rtl/task_scheduler_slice_timer.sv
// Time-slice down-counter: reloads on expiry or explicit reload, flags expiry in the tick cycle.
module task_scheduler_slice_timer
   import scheduler_pkg::*;
#(
   parameter int unsigned SLICE_TICKS = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_tick,
   input  logic i_reload,
   output logic o_expire_c
);

   localparam logic [SLICE_W-1:0] RELOAD_VAL = SLICE_W'(SLICE_TICKS - 1);

   logic [SLICE_W-1:0] r_cnt;
   logic               w_expire;

   // Expiry is combinational so a same-cycle reschedule merges into one request.
   assign w_expire   = i_tick && (r_cnt == '0);
   assign o_expire_c = w_expire;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= RELOAD_VAL;
      end else if (i_reload || w_expire) begin
         r_cnt <= RELOAD_VAL;
      end else if (i_tick) begin
         r_cnt <= r_cnt - SLICE_W'(1);
      end
   end

endmodule

// File: rtl/task_scheduler.sv
// Scheduling front-end: scans ready-list priority levels on slice expiry or yield and commits the winner.
// Optional SCHED_STATS_EN adds switch_cnt_o / idle_cnt_o commit counters.
module task_scheduler
   import scheduler_pkg::*;
#(
   parameter int unsigned       NPRI        = 5,
   parameter int unsigned       SLICE_TICKS = 4,
   parameter logic [TID_W-1:0]  IDLE_TID    = 6'd0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 tick_i,
   input  logic                 resched_i,
   output logic                 rl_get_o,
   output logic [PRI_W-1:0]     rl_priority_o,
   input  logic [RL_TID_W-1:0]  rl_tid_i,
   input  logic                 rl_done_i,
   output logic [TID_W-1:0]     run_tid_o,
   output logic                 run_valid_o,
   output logic                 switch_o,
`ifdef SCHED_STATS_EN
   output logic [STAT_W-1:0]    switch_cnt_o,
   output logic [STAT_W-1:0]    idle_cnt_o,
`endif
   output logic                 busy_o
);

   localparam logic [PRI_W-1:0] LAST_PRI = PRI_W'(NPRI - 1);

   sched_state_e r_state;
   logic         r_pend;
   logic         w_expire;
   logic         w_reload;
   logic         w_req;

   assign w_reload = resched_i && (r_state == IDLE);
   assign w_req    = resched_i || w_expire;

   task_scheduler_slice_timer #(
      .SLICE_TICKS (SLICE_TICKS)
   ) u_slice_timer (
      .i_clk      (clk_i),
      .i_rst      (rst_i),
      .i_tick     (tick_i),
      .i_reload   (w_reload),
      .o_expire_c (w_expire)
   );

   // rl_priority_o doubles as the current scan level and only moves when a new get issues.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= IDLE;
         r_pend        <= 1'b0;
         rl_get_o      <= 1'b0;
         rl_priority_o <= '0;
         run_tid_o     <= IDLE_TID;
         run_valid_o   <= 1'b0;
         switch_o      <= 1'b0;
         busy_o        <= 1'b0;
`ifdef SCHED_STATS_EN
         switch_cnt_o  <= '0;
         idle_cnt_o    <= '0;
`endif
      end else begin
         rl_get_o <= 1'b0;
         switch_o <= 1'b0;

         case (r_state)
            IDLE: begin
               if ((r_pend || w_req) && rl_done_i) begin
                  r_state       <= ISSUE;
                  r_pend        <= 1'b0;
                  rl_get_o      <= 1'b1;
                  rl_priority_o <= '0;
                  busy_o        <= 1'b1;
               end else if (w_req) begin
                  r_pend <= 1'b1;
               end
            end

            ISSUE: begin
               r_state <= WAIT0;
            end

            WAIT0: begin
               r_state <= WAIT1;
            end

            WAIT1: begin
               if (rl_done_i) begin
                  if ((rl_tid_i == TID_EMPTY) && (rl_priority_o != LAST_PRI)) begin
                     r_state       <= ISSUE;
                     rl_get_o      <= 1'b1;
                     rl_priority_o <= rl_priority_o + PRI_W'(1);
                  end else begin
                     r_state  <= COMMIT;
                     switch_o <= 1'b1;
                     busy_o   <= 1'b0;
`ifdef SCHED_STATS_EN
                     switch_cnt_o <= switch_cnt_o + STAT_W'(1);
`endif
                     if (rl_tid_i == TID_EMPTY) begin
                        run_tid_o   <= IDLE_TID;
                        run_valid_o <= 1'b0;
`ifdef SCHED_STATS_EN
                        idle_cnt_o  <= idle_cnt_o + STAT_W'(1);
`endif
                     end else begin
                        run_tid_o   <= tid_of(rl_tid_i);
                        run_valid_o <= 1'b1;
                     end
                  end
               end
            end

            COMMIT: begin
               r_state <= IDLE;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase

         // Requests during a scan coalesce into a single follow-up scan.
         if ((r_state != IDLE) && w_req) begin
            r_pend <= 1'b1;
         end
      end
   end

endmodule
